median3x3_stream: RTL and testbench
===================================

// Module: median3x3_stream
// PURPOSE
// - Streaming 3x3 median denoiser directly upstream of resize_filter.
// - Takes noisy 8-bit pixels in raster order and removes salt-and-pepper noise.
// - Emits one cleaned pixel per accepted input, in the same raster order, as the load stream for resize_filter.
// - Two line buffers plus a 3x3 window; one pipelined median network; no frame store.
// PARAMETERS
// - WIDTH   410  pixels per row (>=3)
// - HEIGHT  361  rows per frame (>=3)
// - PIX_W   8    bits per pixel
// PORTS
// - clk         in   1      single clock, rising edge
// - rst         in   1      asynchronous, active-high reset
// - in_valid    in   1      pixel_in valid this cycle
// - in_ready    out  1      block accepts pixel_in; transfer = in_valid & in_ready
// - pixel_in    in   PIX_W  noisy pixel, raster order, row 0 first
// - out_valid   out  1      pixel_out valid; no backpressure (feeds resize_filter enable)
// - pixel_out   out  PIX_W  filtered pixel, raster order
// - frame_done  out  1      one-cycle pulse together with the last output pixel of a frame
// BEHAVIOUR
// - Reset (async, rst=1): in_ready=0, out_valid=0, pixel_out=0, frame_done=0.
//   Counters, state and window are cleared. Line-buffer contents are don't-care.
//   A frame in progress is discarded; after release the next accepted pixel is (0,0).
// - States: IDLE -> RUN -> FLUSH -> DONE -> IDLE.
//   - IDLE: in_ready=1. First transfer moves to RUN.
//   - RUN: in_ready=1. Accepts WIDTH*HEIGHT pixels total; in_valid gaps stall the whole pipe.
//   - FLUSH: entered after the last input transfer; in_ready=0.
//     Pipe self-advances one position per cycle for WIDTH+1 cycles, feeding zeros.
//   - DONE: one cycle, in_ready=0; then IDLE.
// - Window: center pixel k (raster index) is complete when input k+WIDTH+1 is accepted, or the equivalent flush step.
// - Median network: 3 register stages.
//   - Stage 1: sort each column of 3.
//   - Stage 2: max of mins, med of meds, min of maxes.
//   - Stage 3: median of those 3.
// - Latency: out_valid for center k asserts exactly 3 advancing cycles after its window completes.
//   Stalls (in_valid=0 in RUN) freeze stages and hold out_valid=0.
// - Border rule: if the center is in row 0, row HEIGHT-1, col 0 or col WIDTH-1, pixel_out = center pixel unmodified.
//   The border value is still delayed through the same 3 stages, so latency is identical.
// - Exactly WIDTH*HEIGHT out_valid pulses per frame. frame_done coincides with the pulse for index WIDTH*HEIGHT-1.
// - Column and row counters wrap at WIDTH-1 / HEIGHT-1. Row/col flags are computed from the center, not the input position.
// - in_valid asserted while in_ready=0 is ignored, with no side effects.
// - All arithmetic is unsigned PIX_W compare/select only; no sums, no overflow.
// STRUCTURE
// - Shared include filter_defs.vh holds:
//   - PIX_W default
//   - WIDTH/HEIGHT defaults
//   - FSM state encodings (IDLE=0, RUN=1, FLUSH=2, DONE=3)
// - Sub-module line_buffer (depth WIDTH, width PIX_W, shift-enable) is instantiated twice.
// - Top level holds: FSM, counters, 3x3 window registers, median stages, border bypass pipeline.
// TESTING (bench: WIDTH=8, HEIGHT=6 unless noted)
// - Constant frame, all 50, in_valid held 1 -> 48 outputs all 50.
//   frame_done on the 48th output; in_ready low for 9+1 cycles after last input.
// - Zero frame with impulse 255 at (3,4) -> all outputs 0.
//   Impulse at border (0,2) -> output (0,2)=255, all others 0.
// - Ramp pixel=(row*8+col) -> interior outputs equal input (monotone neighbourhood); borders equal input.
// - Random in_valid gaps (~30% idle) on random frame -> output sequence identical to the gap-free run.
//   Still 48 outputs and one frame_done.
// - rst pulsed mid-RUN after 20 pixels -> outputs 0 immediately.
//   A fresh full frame afterwards gives correct 48 outputs with no stale data.
// - Back-to-back frames (second frame's in_valid waiting in DONE) -> second frame accepted from IDLE.
//   Both frames bit-exact against the reference model.

Source files
------------

// File: rtl/median3x3_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : median3x3_stream_pkg
// Brief    : Shared defaults and FSM encodings for the 3x3 median stream.
// Revision : 1.0 - initial release
// ============================================================================
package median3x3_stream_pkg;

    localparam int c_pix_w_def  = 8;
    localparam int c_width_def  = 410;
    localparam int c_height_def = 361;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_flush = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/median3x3_stream_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : median3x3_stream_line_buffer
// Brief    : Circular-pointer delay line; dout is the sample written DEPTH
//            enabled cycles earlier.
// Revision : 1.0 - initial release
// ============================================================================
module median3x3_stream_line_buffer #(
    parameter int DEPTH  = 410,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ptr <= '0;
        else if (en)
            r_ptr <= (r_ptr == c_ptr_last) ? '0 : r_ptr + 1'b1;
    end

    // Storage is left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (en)
            r_mem[r_ptr] <= din;
    end

    assign dout = r_mem[r_ptr];

endmodule
`default_nettype wire

// File: rtl/median3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : median3x3_stream
// Brief    : Streaming 3x3 median denoiser, raster in / raster out, borders
//            passed through with identical latency.
// Revision : 1.0 - initial release
// ============================================================================
module median3x3_stream
    import median3x3_stream_pkg::*;
#(
    parameter int WIDTH  = c_width_def,
    parameter int HEIGHT = c_height_def,
    parameter int PIX_W  = c_pix_w_def
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] pixel_in,
    output logic             out_valid,
    output logic [PIX_W-1:0] pixel_out,
    output logic             frame_done
);

    localparam int c_npix  = WIDTH * HEIGHT;
    localparam int c_cnt_w = $clog2(c_npix + WIDTH + 1);
    localparam int c_col_w = $clog2(WIDTH);
    localparam int c_row_w = $clog2(HEIGHT);
    localparam logic [c_cnt_w-1:0] c_cnt_last_in = c_cnt_w'(c_npix - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last    = c_cnt_w'(c_npix + WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_win     = c_cnt_w'(WIDTH + 1);
    localparam logic [c_col_w-1:0] c_col_last    = c_col_w'(WIDTH - 1);
    localparam logic [c_row_w-1:0] c_row_last    = c_row_w'(HEIGHT - 1);

    function automatic logic [PIX_W-1:0] f_min(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [PIX_W-1:0] f_max(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [PIX_W-1:0] f_med(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                               input logic [PIX_W-1:0] c);
        return f_max(f_min(a, b), f_min(f_max(a, b), c));
    endfunction

    logic [1:0]         r_state, w_next_state;
    logic               r_in_ready;
    logic [c_cnt_w-1:0] r_adv_cnt;
    logic [c_col_w-1:0] r_ccol;
    logic [c_row_w-1:0] r_crow;
    logic               w_xfer, w_adv, w_stage_en, w_load_valid, w_border;
    logic [PIX_W-1:0]   w_feed, w_lb0_out, w_lb1_out;

    logic [PIX_W-1:0] r_win [3][3];
    logic [PIX_W-1:0] w_lo [3];
    logic [PIX_W-1:0] w_md [3];
    logic [PIX_W-1:0] w_hi [3];
    logic [PIX_W-1:0] r_s1_lo [3];
    logic [PIX_W-1:0] r_s1_md [3];
    logic [PIX_W-1:0] r_s1_hi [3];
    logic [PIX_W-1:0] r_s2_a, r_s2_b, r_s2_c, r_ctr1, r_ctr2;
    logic [2:0]       r_vld, r_bdr, r_last;

    assign w_xfer       = in_valid & r_in_ready;
    assign w_adv        = w_xfer | (r_state == c_st_flush);
    assign w_feed       = (r_state == c_st_flush) ? '0 : pixel_in;
    assign w_load_valid = (r_adv_cnt >= c_cnt_win);
    assign w_border     = (r_crow == '0) || (r_crow == c_row_last) ||
                          (r_ccol == '0) || (r_ccol == c_col_last);
    // Stages only hold still on a RUN stall once this frame's first window is
    // loaded; otherwise they drain the previous frame's tail freely.
    assign w_stage_en   = w_adv || (r_state != c_st_run) || (r_adv_cnt <= c_cnt_win);
    assign in_ready     = r_in_ready;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:  if (w_xfer) w_next_state = c_st_run;
            c_st_run:   if (w_xfer && (r_adv_cnt == c_cnt_last_in)) w_next_state = c_st_flush;
            c_st_flush: if (r_adv_cnt == c_cnt_last) w_next_state = c_st_done;
            default:    w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_in_ready <= 1'b0;
            r_adv_cnt  <= '0;
            r_ccol     <= '0;
            r_crow     <= '0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state == c_st_idle) || (w_next_state == c_st_run);
            if (w_adv)
                r_adv_cnt <= (r_adv_cnt == c_cnt_last) ? '0 : r_adv_cnt + 1'b1;
            if (w_adv && w_load_valid) begin
                r_ccol <= (r_ccol == c_col_last) ? '0 : r_ccol + 1'b1;
                if (r_ccol == c_col_last)
                    r_crow <= (r_crow == c_row_last) ? '0 : r_crow + 1'b1;
            end
        end
    end

    median3x3_stream_line_buffer #(.DEPTH(WIDTH), .DATA_W(PIX_W)) u_lb0 (
        .clk(clk), .rst(rst), .en(w_adv), .din(w_feed), .dout(w_lb0_out)
    );

    median3x3_stream_line_buffer #(.DEPTH(WIDTH), .DATA_W(PIX_W)) u_lb1 (
        .clk(clk), .rst(rst), .en(w_adv), .din(w_lb0_out), .dout(w_lb1_out)
    );

    for (genvar gc = 0; gc < 3; gc++) begin : g_col
        assign w_lo[gc] = f_min(f_min(r_win[0][gc], r_win[1][gc]), r_win[2][gc]);
        assign w_md[gc] = f_med(r_win[0][gc], r_win[1][gc], r_win[2][gc]);
        assign w_hi[gc] = f_max(f_max(r_win[0][gc], r_win[1][gc]), r_win[2][gc]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++)
                    r_win[r][c] <= '0;
                r_s1_lo[r] <= '0;
                r_s1_md[r] <= '0;
                r_s1_hi[r] <= '0;
            end
            r_s2_a     <= '0;
            r_s2_b     <= '0;
            r_s2_c     <= '0;
            r_ctr1     <= '0;
            r_ctr2     <= '0;
            r_vld      <= '0;
            r_bdr      <= '0;
            r_last     <= '0;
            out_valid  <= 1'b0;
            pixel_out  <= '0;
            frame_done <= 1'b0;
        end else begin
            if (w_adv) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_lb1_out;
                r_win[1][2] <= w_lb0_out;
                r_win[2][2] <= w_feed;
                r_vld[0]    <= w_load_valid;
                r_bdr[0]    <= w_border;
                r_last[0]   <= (r_adv_cnt == c_cnt_last);
            end else if (w_stage_en) begin
                r_vld[0] <= 1'b0;
            end

            if (w_stage_en) begin
                r_s1_lo    <= w_lo;
                r_s1_md    <= w_md;
                r_s1_hi    <= w_hi;
                r_ctr1     <= r_win[1][1];
                r_s2_a     <= f_max(f_max(r_s1_lo[0], r_s1_lo[1]), r_s1_lo[2]);
                r_s2_b     <= f_med(r_s1_md[0], r_s1_md[1], r_s1_md[2]);
                r_s2_c     <= f_min(f_min(r_s1_hi[0], r_s1_hi[1]), r_s1_hi[2]);
                r_ctr2     <= r_ctr1;
                r_vld[2:1] <= r_vld[1:0];
                r_bdr[2:1] <= r_bdr[1:0];
                r_last[2:1] <= r_last[1:0];
                pixel_out  <= r_bdr[2] ? r_ctr2 : f_med(r_s2_a, r_s2_b, r_s2_c);
                out_valid  <= r_vld[2];
                frame_done <= r_vld[2] & r_last[2];
            end else begin
                out_valid  <= 1'b0;
                frame_done <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_median3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_median3x3_stream
// Brief    : Directed self-checking bench for median3x3_stream (8x6 frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_median3x3_stream;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] pixel_in = 8'd0;
    logic       in_ready, out_valid, frame_done;
    logic [7:0] pixel_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fr [N];
    logic [7:0] exp_q [$];
    logic [7:0] out_q [$];
    logic [7:0] keep_q [$];
    int         fd_pos [$];

    median3x3_stream #(.WIDTH(W), .HEIGHT(H), .PIX_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pixel_in(pixel_in), .out_valid(out_valid), .pixel_out(pixel_out),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid) out_q.push_back(pixel_out);
        if (frame_done) fd_pos.push_back(out_q.size());
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Reference: sort the 9 neighbours and take the fifth; borders pass through.
    task automatic build_expected();
        logic [7:0] v [9];
        logic [7:0] t;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
                    exp_q.push_back(fr[r * W + c]);
                end else begin
                    for (int k = 0; k < 9; k++) v[k] = fr[(r + k / 3 - 1) * W + (c + k % 3 - 1)];
                    for (int a = 0; a < 9; a++)
                        for (int b = 0; b < 8 - a; b++)
                            if (v[b] > v[b + 1]) begin t = v[b]; v[b] = v[b + 1]; v[b + 1] = t; end
                    exp_q.push_back(v[4]);
                end
            end
        end
    endtask

    task automatic drive_frame(input int gap_pct, input int count);
        int t;
        for (int i = 0; i < count; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            pixel_in = fr[i];
            t = 0;
            while (!in_ready && t < 100) begin @(negedge clk); t++; end
            n_checks++;
            if (!in_ready) begin
                n_fail++;
                $display("FAIL in_ready_wait got %0b want 1", in_ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_outputs(input int n);
        int t = 0;
        while (out_q.size() < n && t < 400) begin @(negedge clk); t++; end
        repeat (6) @(negedge clk);
    endtask

    task automatic clear_capture();
        out_q.delete();
        exp_q.delete();
        fd_pos.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks += 4;
        if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        if (pixel_out !== 8'd0)  begin n_fail++; $display("FAIL rst_pixel_out got %0d want 0", pixel_out); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_constant();
        int lo = 0;
        clear_capture();
        for (int i = 0; i < N; i++) fr[i] = 8'd50;
        drive_frame(0, N);
        in_valid = 1'b0;
        while (!in_ready && lo < 50) begin lo++; @(negedge clk); end
        n_checks++;
        if (lo != W + 2) begin n_fail++; $display("FAIL const_ready_low got %0d want %0d", lo, W + 2); end
        wait_outputs(N);
        n_checks += 2;
        if (out_q.size() != N) begin n_fail++; $display("FAIL const_count got %0d want %0d", out_q.size(), N); end
        if (fd_pos.size() != 1 || fd_pos[0] != N) begin
            n_fail++; $display("FAIL const_frame_done got %0d pulses want 1 at %0d", fd_pos.size(), N);
        end
        for (int i = 0; i < out_q.size() && i < N; i++) begin
            n_checks++;
            if (out_q[i] !== 8'd50) begin n_fail++; $display("FAIL const_pix[%0d] got %0d want 50", i, out_q[i]); end
        end
    endtask

    task automatic test_impulse();
        for (int pass = 0; pass < 2; pass++) begin
            clear_capture();
            for (int i = 0; i < N; i++) fr[i] = 8'd0;
            if (pass == 0) fr[3 * W + 4] = 8'd255;
            else           fr[2] = 8'd255;
            drive_frame(0, N);
            in_valid = 1'b0;
            wait_outputs(N);
            n_checks++;
            if (out_q.size() != N) begin n_fail++; $display("FAIL impulse%0d_count got %0d want %0d", pass, out_q.size(), N); end
            for (int i = 0; i < out_q.size() && i < N; i++) begin
                n_checks++;
                if (out_q[i] !== ((pass == 1 && i == 2) ? 8'd255 : 8'd0)) begin
                    n_fail++; $display("FAIL impulse%0d_pix[%0d] got %0d want %0d", pass, i, out_q[i],
                                       (pass == 1 && i == 2) ? 255 : 0);
                end
            end
        end
    endtask

    task automatic test_ramp();
        clear_capture();
        for (int i = 0; i < N; i++) fr[i] = 8'(i);
        drive_frame(0, N);
        in_valid = 1'b0;
        wait_outputs(N);
        n_checks++;
        if (out_q.size() != N) begin n_fail++; $display("FAIL ramp_count got %0d want %0d", out_q.size(), N); end
        for (int i = 0; i < out_q.size() && i < N; i++) begin
            n_checks++;
            if (out_q[i] !== 8'(i)) begin n_fail++; $display("FAIL ramp_pix[%0d] got %0d want %0d", i, out_q[i], i); end
        end
    endtask

    task automatic test_gaps();
        clear_capture();
        for (int i = 0; i < N; i++) fr[i] = 8'($urandom_range(0, 255));
        build_expected();
        drive_frame(0, N);
        in_valid = 1'b0;
        wait_outputs(N);
        keep_q = out_q;
        out_q.delete();
        fd_pos.delete();
        drive_frame(30, N);
        in_valid = 1'b0;
        wait_outputs(N);
        n_checks += 3;
        if (keep_q.size() != N) begin n_fail++; $display("FAIL gapfree_count got %0d want %0d", keep_q.size(), N); end
        if (out_q.size() != N)  begin n_fail++; $display("FAIL gaps_count got %0d want %0d", out_q.size(), N); end
        if (fd_pos.size() != 1 || fd_pos[0] != N) begin
            n_fail++; $display("FAIL gaps_frame_done got %0d pulses want 1 at %0d", fd_pos.size(), N);
        end
        for (int i = 0; i < N && i < out_q.size() && i < keep_q.size(); i++) begin
            n_checks += 2;
            if (keep_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL gapfree_pix[%0d] got %0d want %0d", i, keep_q[i], exp_q[i]); end
            if (out_q[i] !== keep_q[i]) begin n_fail++; $display("FAIL gaps_pix[%0d] got %0d want %0d", i, out_q[i], keep_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < N; i++) fr[i] = 8'($urandom_range(1, 255));
        drive_frame(0, 20);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks += 4;
        if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        if (pixel_out !== 8'd0)  begin n_fail++; $display("FAIL midrst_pixel_out got %0d want 0", pixel_out); end
        if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL midrst_in_ready got %b want 0", in_ready); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_done got %b want 0", frame_done); end
        @(negedge clk);
        rst = 1'b0;
        clear_capture();
        for (int i = 0; i < N; i++) fr[i] = 8'($urandom_range(0, 255));
        build_expected();
        drive_frame(0, N);
        in_valid = 1'b0;
        wait_outputs(N);
        n_checks += 2;
        if (out_q.size() != N) begin n_fail++; $display("FAIL postrst_count got %0d want %0d", out_q.size(), N); end
        if (fd_pos.size() != 1 || fd_pos[0] != N) begin
            n_fail++; $display("FAIL postrst_frame_done got %0d pulses want 1 at %0d", fd_pos.size(), N);
        end
        for (int i = 0; i < out_q.size() && i < N; i++) begin
            n_checks++;
            if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL postrst_pix[%0d] got %0d want %0d", i, out_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_capture();
        for (int i = 0; i < N; i++) fr[i] = 8'($urandom_range(0, 255));
        build_expected();
        drive_frame(0, N);
        for (int i = 0; i < N; i++) fr[i] = 8'($urandom_range(0, 255));
        build_expected();
        drive_frame(0, N);
        in_valid = 1'b0;
        wait_outputs(2 * N);
        n_checks += 2;
        if (out_q.size() != 2 * N) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", out_q.size(), 2 * N); end
        if (fd_pos.size() != 2 || fd_pos[0] != N || fd_pos[1] != 2 * N) begin
            n_fail++; $display("FAIL b2b_frame_done got %0d pulses want 2 at %0d,%0d", fd_pos.size(), N, 2 * N);
        end
        for (int i = 0; i < out_q.size() && i < 2 * N; i++) begin
            n_checks++;
            if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_pix[%0d] got %0d want %0d", i, out_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_impulse();
        test_ramp();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
